// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit with HI/LO registers for the execute stage.
// Operands are latched at start; the result commits after a fixed cycle count.
module md_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_e;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5,
    OP_RSV6  = 3'd6,
    OP_RSV7  = 3'd7
  } op_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  op_e              op_q, op_d;
  logic [31:0]      a_q, a_d;
  logic [31:0]      b_q, b_d;
  logic [31:0]      hi_q, hi_d;
  logic [31:0]      lo_q, lo_d;
  logic             done_q, done_d;

  // Datapath works only on latched operands.
  logic        is_signed_mul;
  logic [63:0] ext_a, ext_b, prod;

  assign is_signed_mul = (op_q == OP_MULT);
  assign ext_a = {{32{is_signed_mul & a_q[31]}}, a_q};
  assign ext_b = {{32{is_signed_mul & b_q[31]}}, b_q};
  // Low 64 bits of the extended product are correct for both signednesses.
  assign prod  = ext_a * ext_b;

  logic        is_signed_div, a_neg, b_neg, div_by_zero;
  logic [31:0] mag_a, mag_b, safe_b, uquo, urem, quo, rem;

  assign is_signed_div = (op_q == OP_DIV);
  assign a_neg         = is_signed_div & a_q[31];
  assign b_neg         = is_signed_div & b_q[31];
  assign div_by_zero   = (b_q == 32'd0);
  assign mag_a         = a_neg ? (~a_q + 32'd1) : a_q;
  assign mag_b         = b_neg ? (~b_q + 32'd1) : b_q;
  assign safe_b        = div_by_zero ? 32'd1 : mag_b;
  assign uquo          = mag_a / safe_b;
  assign urem          = mag_a % safe_b;
  // Magnitude divide handles 0x80000000 / -1 without overflow: quotient stays 0x80000000.
  assign quo           = (a_neg ^ b_neg) ? (~uquo + 32'd1) : uquo;
  assign rem           = a_neg ? (~urem + 32'd1) : urem;

  always_comb begin
    // NOTE: every _d takes its hold value first, so no path through this block infers a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          unique case (md_op)
            OP_MULT, OP_MULTU: begin
              op_d    = op_e'(md_op);
              a_d     = src_a;
              b_d     = src_b;
              cnt_d   = CNT_W'(MULT_CYCLES);
              state_d = S_RUN;
            end
            OP_DIV, OP_DIVU: begin
              op_d    = op_e'(md_op);
              a_d     = src_a;
              b_d     = src_b;
              cnt_d   = CNT_W'(DIV_CYCLES);
              state_d = S_RUN;
            end
            OP_MTHI: hi_d = src_a;
            OP_MTLO: lo_d = src_a;
            default: ;
          endcase
        end
      end

      S_RUN: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
          unique case (op_q)
            OP_MULT, OP_MULTU: {hi_d, lo_d} = prod;
            OP_DIV, OP_DIVU: begin
              if (!div_by_zero) begin
                lo_d = quo;
                hi_d = rem;
              end
            end
            default: ;
          endcase
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: clocked state uses <= only, so every register samples pre-edge values.
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= OP_MULT;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
    end
  end

  assign busy = (state_q == S_RUN);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: directed vector table, corner sequences,
// and randomized operations against an arithmetic reference model.
module tb_md_unit;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  md_op;
  logic [31:0] src_a, src_b;
  logic        busy, done;
  logic [31:0] hi, lo;

  int pass_cnt  = 0;
  int total_cnt = 0;

  logic [31:0] m_hi, m_lo;

  md_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .md_op (md_op),
    .src_a (src_a),
    .src_b (src_b),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] eh;
    logic [31:0] el;
    string       name;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  // Reference: MIPS HI/LO semantics from plain 64-bit arithmetic.
  function automatic void model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                inout logic [31:0] h, inout logic [31:0] l);
    longint          sa, sb, sp;
    longint unsigned ua, ub, up;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (op)
      3'd0: begin sp = sa * sb; {h, l} = sp; end
      3'd1: begin up = ua * ub; {h, l} = up; end
      3'd2: if (b != 0) begin l = 32'(sa / sb); h = 32'(sa % sb); end
      3'd3: if (b != 0) begin l = a / b; h = a % b; end
      3'd4: h = a;
      3'd5: l = a;
      default: ;
    endcase
  endfunction

  // Present a start at the current negedge and follow it to completion.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eh, input logic [31:0] el, input string name,
                        input bit poke, input bit tail);
    int n;
    int cyc;
    n = (op < 3'd2) ? MC : DC;
    start = 1'b1; md_op = op; src_a = a; src_b = b;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (busy === 1'b1 && cyc < 200) begin
      cyc++;
      src_a = $urandom;
      src_b = $urandom;
      if (poke && cyc == 3) begin
        start = 1'b1;
        md_op = 3'($urandom_range(0, 7));
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    check({name, " busy_cycles"}, 64'(cyc), 64'(n));
    check({name, " done"}, {63'd0, done}, 64'd1);
    check({name, " hi"}, {32'd0, hi}, {32'd0, eh});
    check({name, " lo"}, {32'd0, lo}, {32'd0, el});
    if (tail) begin
      @(negedge clk);
      check({name, " done_clear"}, {63'd0, done}, 64'd0);
    end
  endtask

  initial begin
    int done_seen;
    logic [2:0]  r_op;
    logic [31:0] r_a, r_b;

    vecs[0] = '{3'd0, 32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 32'hFFFFFFFA, "mult_neg2x3"};
    vecs[1] = '{3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, "multu_max"};
    vecs[2] = '{3'd2, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, "div_neg7by2"};
    vecs[3] = '{3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, "div_min_by_m1"};
    vecs[4] = '{3'd3, 32'd100,      32'd7,        32'd2,        32'd14,       "divu_100by7"};
    vecs[5] = '{3'd2, 32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, "div_7bym2"};
    vecs[6] = '{3'd0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, "mult_min_sq"};
    vecs[7] = '{3'd1, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, "multu_2p32"};
    vecs[8] = '{3'd3, 32'hFFFFFFFF, 32'd16,       32'h0000000F, 32'h0FFFFFFF, "divu_max_by16"};

    reset = 1'b0; start = 1'b0; md_op = 3'd0; src_a = '0; src_b = '0;
    repeat (2) @(negedge clk);
    check("reset hi", {32'd0, hi}, 64'd0);
    check("reset lo", {32'd0, lo}, 64'd0);
    check("reset busy", {63'd0, busy}, 64'd0);
    check("reset done", {63'd0, done}, 64'd0);
    reset = 1'b1;
    @(negedge clk);

    foreach (vecs[i])
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].eh, vecs[i].el, vecs[i].name, 1'b0, 1'b1);
    m_hi = vecs[8].eh; m_lo = vecs[8].el;

    // mthi then mtlo on consecutive edges.
    start = 1'b1; md_op = 3'd4; src_a = 32'h1234;
    @(negedge clk);
    check("mthi hi", {32'd0, hi}, 64'h1234);
    check("mthi lo_kept", {32'd0, lo}, {32'd0, m_lo});
    check("mthi busy", {63'd0, busy}, 64'd0);
    md_op = 3'd5; src_a = 32'h5678;
    @(negedge clk);
    start = 1'b0;
    check("mtlo lo", {32'd0, lo}, 64'h5678);
    check("mtlo hi_kept", {32'd0, hi}, 64'h1234);
    check("mtlo done", {63'd0, done}, 64'd0);
    m_hi = 32'h1234; m_lo = 32'h5678;

    // Divide by zero, with an ignored start poked into the busy window.
    run_op(3'd3, 32'd99, 32'd0, 32'h1234, 32'h5678, "divu_by_zero", 1'b1, 1'b1);

    // Reset in the middle of a divide.
    start = 1'b1; md_op = 3'd2; src_a = 32'd100; src_b = 32'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("midreset hi", {32'd0, hi}, 64'd0);
    check("midreset lo", {32'd0, lo}, 64'd0);
    check("midreset busy", {63'd0, busy}, 64'd0);
    check("midreset done", {63'd0, done}, 64'd0);
    reset = 1'b1;
    done_seen = 0;
    repeat (15) begin
      @(negedge clk);
      if (done) done_seen++;
    end
    check("midreset no_done", 64'(done_seen), 64'd0);
    m_hi = 32'd0; m_lo = 32'd0;

    run_op(3'd1, 32'd6, 32'd7, 32'd0, 32'd42, "multu_6x7", 1'b0, 1'b1);

    // Back-to-back: second start on the first cycle busy is low.
    run_op(3'd0, 32'd3, 32'd4, 32'd0, 32'd12, "b2b_mult", 1'b0, 1'b0);
    run_op(3'd3, 32'd100, 32'd7, 32'd2, 32'd14, "b2b_divu", 1'b0, 1'b1);
    m_hi = 32'd2; m_lo = 32'd14;

    // Randomized operations against the model.
    for (int k = 0; k < 60; k++) begin
      r_op = 3'($urandom_range(0, 7));
      r_a  = $urandom;
      r_b  = ($urandom_range(0, 7) == 0) ? 32'd0 :
             ($urandom_range(0, 1) == 0) ? 32'($urandom_range(1, 300)) : 32'($urandom);
      if ($urandom_range(0, 3) == 0) r_a = 32'h80000000;
      model(r_op, r_a, r_b, m_hi, m_lo);
      if (r_op < 3'd4) begin
        run_op(r_op, r_a, r_b, m_hi, m_lo, $sformatf("rand%0d_op%0d", k, r_op),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end else begin
        start = 1'b1; md_op = r_op; src_a = r_a; src_b = r_b;
        @(negedge clk);
        start = 1'b0;
        check($sformatf("rand%0d_op%0d hi", k, r_op), {32'd0, hi}, {32'd0, m_hi});
        check($sformatf("rand%0d_op%0d lo", k, r_op), {32'd0, lo}, {32'd0, m_lo});
        check($sformatf("rand%0d_op%0d busy", k, r_op), {63'd0, busy}, 64'd0);
        check($sformatf("rand%0d_op%0d done", k, r_op), {63'd0, done}, 64'd0);
      end
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/md_unit.md
# md_unit

Multi-cycle multiply/divide unit beside the ALU in the execute stage. It consumes the two register-file operands (ScrA/RD2) that the datapath already routes to the ALU and computes MIPS mult/multu/div/divu results into internal HI/LO registers. It also services mthi/mtlo writes. It exposes `busy` so the controller can stall instructions that touch HI/LO.

## Interface
- MULT_CYCLES, 5, cycles from accepted start to HI/LO update for mult/multu (≥1)
- DIV_CYCLES, 10, cycles from accepted start to HI/LO update for div/divu (≥1)

- clk  input  1  system clock, all state on rising edge
- reset  input  1  synchronous, active-low: state clears on a rising edge where reset==0
- start  input  1  request strobe, qualified by md_op
- md_op  input  3  0=mult, 1=multu, 2=div, 3=divu, 4=mthi, 5=mtlo, 6–7 reserved (no-op)
- src_a  input  32  rs operand (dividend / multiplicand / mthi-mtlo data)
- src_b  input  32  rt operand (divisor / multiplier)
- busy  output  1  operation in flight
- done  output  1  one-cycle pulse on the cycle after HI/LO update
- hi  output  32  HI register
- lo  output  32  LO register

## Operation
- States: IDLE, RUN. A down-counter `cnt` tracks RUN.
- IDLE, start=1, md_op∈{0..3}:
  - latch src_a, src_b, and md_op;
  - load cnt=MULT_CYCLES or DIV_CYCLES;
  - go to RUN; busy=1.
- IDLE, start=1, md_op=4: hi<=src_a at this edge. md_op=5: lo<=src_a. No busy, no done.
- IDLE, start=1, md_op 6–7: ignored.
- RUN: cnt decrements each edge. On the edge where cnt==1:
  - commit the result to hi/lo;
  - return to IDLE; busy<=0; done<=1 for one cycle.
- Results use latched operands only. src_a/src_b changes during RUN have no effect.
- mult: {hi,lo} = signed(a)×signed(b), 64-bit.
- multu: {hi,lo} = unsigned 64-bit product.
- div: lo = quotient truncated toward zero; hi = remainder, same sign as the dividend.
  - 0x80000000 / 0xFFFFFFFF → lo=0x80000000, hi=0x00000000.
- divu: unsigned quotient to lo, remainder to hi.
- Divide by zero (b==0): run the full DIV_CYCLES, then leave hi/lo unchanged; done still pulses.
- Any start (all md_op values, including mthi/mtlo) while busy=1 is ignored. Nothing is queued and hi/lo stay untouched.
- Internal arithmetic may be combinational on latched operands or iterative. Externally visible timing must match the counts above exactly.

## Timing
- Reset values: hi=0, lo=0, busy=0, done=0, state=IDLE, cnt=0.
- reset==0 overrides everything, including an in-flight RUN: the operation is aborted, no result is committed, and all outputs take their reset values at that edge.
- Start accepted at edge T → busy=1 after T. The result is committed at edge T+N (N = MULT_CYCLES or DIV_CYCLES), so busy is high for exactly N cycles.
- New hi/lo values are visible after T+N. busy=0 and done=1 are visible after T+N; done=0 after T+N+1.
- Back-to-back: a start presented in the cycle after T+N (busy=0) is accepted. No dead cycle is required.
- mthi/mtlo: a single edge, visible next cycle.
- With start held high in IDLE, a new operation is accepted each time busy is low at an edge.

## Test plan
- Reset, then mult with a=0xFFFFFFFE (−2), b=3 → busy high 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA; done pulses once.
- multu with a=0xFFFFFFFF, b=0xFFFFFFFF → after 5 cycles hi=0xFFFFFFFE, lo=0x00000001. Toggling src_a during RUN changes nothing.
- Signed divide cases:
  - div a=−7 (0xFFFFFFF9), b=2 → after 10 cycles lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - div a=0x80000000, b=0xFFFFFFFF → lo=0x80000000, hi=0.
- Divide by zero and ignored starts:
  - mthi 0x1234 and mtlo 0x5678 in consecutive cycles → hi/lo updated one cycle each.
  - Then divu b=0 → 10-cycle busy; hi=0x1234, lo=0x5678 unchanged; done pulses.
  - A mtlo issued during that busy window is ignored.
- Reset mid-operation:
  - Start div, pull reset low at cycle 4 → hi=lo=0, busy=0, done never pulses.
  - Then a fresh multu 6×7 → lo=42, hi=0 after 5 cycles.
- Back-to-back: mult 3×4, then divu 100/7 issued the first cycle busy=0 → lo=12 after the mult, then lo=14, hi=2 exactly 10 cycles later.
